fwd_hazard_unit: RTL and testbench

- Parametrised successor to the 5-stage forwarding control.
- Produces rs1/rs2/store-data forward selects over NUM_FWD_STAGES result-holding stages, not just fixed MEM/WB.
- Adds a sequential hazard FSM: multi-cycle load-use stall with cycle counter, and data-memory wait freeze via a busy handshake.
- Sits beside ID/EX in the pipeline and drives PC/IF-ID stall, ID/EX bubble and the EX operand muxes.

---
 rtl/fwd_hazard_pkg.sv | 36 +++
 rtl/fwd_match_sel.sv | 42 ++++
 rtl/fwd_hazard_unit.sv | 169 ++++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_hazard_pkg
//  Description : Shared types and helpers for the forwarding / hazard unit.
//                Holds the hazard FSM state enum, the "register file" forward
//                select value and the youngest-match priority function.
//  Revision    : 1.0 - initial release
// ============================================================================
package fwd_hazard_pkg;

  // Upper bound on searched result stages; the match function works on a
  // fixed-width hit vector so it can be shared by every instance.
  localparam int MAX_FWD_STAGES = 7;

  // Forward select value meaning "take the operand from the register file".
  localparam int FWD_SEL_RF = 0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  // Returns (index + 1) of the lowest set hit bit, i.e. the youngest stage
  // holding the value, or FWD_SEL_RF when nothing matches.
  function automatic logic [2:0] youngest_sel(input logic [MAX_FWD_STAGES-1:0] hit);
    logic [2:0] sel;
    sel = 3'(FWD_SEL_RF);
    for (int i = MAX_FWD_STAGES - 1; i >= 0; i--) begin
      if (hit[i]) sel = 3'(i + 1);
    end
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_match_sel.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_match_sel
//  Description : Priority-encoded forward select for one source address.
//                Stage i matches when it writes a nonzero rd equal to addr;
//                output is (lowest matching i) + 1, or 0 when none match.
//  Ports       : addr      - source register address to look up
//                reg_write - per-stage RegWrite
//                rd_addr   - per-stage rd, stage i at [i*REG_AW +: REG_AW]
//                sel       - encoded select
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_match_sel
  import fwd_hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NUM_STAGES = 2,
  parameter int SEL_W      = 2
) (
  input  logic [REG_AW-1:0]            addr,
  input  logic [NUM_STAGES-1:0]        reg_write,
  input  logic [NUM_STAGES*REG_AW-1:0] rd_addr,
  output logic [SEL_W-1:0]             sel
);

  logic [MAX_FWD_STAGES-1:0] hit;

  generate
    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_hit
      assign hit[i] = reg_write[i]
                    & (rd_addr[i*REG_AW +: REG_AW] != '0)
                    & (rd_addr[i*REG_AW +: REG_AW] == addr);
    end
    if (NUM_STAGES < MAX_FWD_STAGES) begin : g_pad
      assign hit[MAX_FWD_STAGES-1:NUM_STAGES] = '0;
    end
  endgenerate

  assign sel = SEL_W'(youngest_sel(hit));

endmodule
`default_nettype wire

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_hazard_unit
//  Description : Operand/store-data forwarding selects over NUM_FWD_STAGES
//                result stages plus a hazard FSM producing multi-cycle
//                load-use stalls and a data-memory wait freeze.
//  Ports       : clk, rst_n (sync, active-low)
//                id_*   - decode-stage sources for load-use detection
//                ex_*   - execute-stage sources / load destination
//                stg_*  - per-stage RegWrite and rd vectors
//                mem_*  - MEM-stage store and its data source
//                dmem_busy - data memory not ready
//                fwd_*_sel, stall_pc, stall_if_id, bubble_id_ex, freeze_all
//  Option      : FWD_HAZARD_PERF_EN adds perf_lu_cycles / perf_wait_cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit
  import fwd_hazard_pkg::*;
#(
  parameter int REG_AW          = 5,
  parameter int NUM_FWD_STAGES  = 2,
  parameter int LOAD_USE_CYCLES = 1,
  parameter int SEL_W           = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [REG_AW-1:0]                id_rs1_addr,
  input  logic [REG_AW-1:0]                id_rs2_addr,
  input  logic                             id_uses_rs1,
  input  logic                             id_uses_rs2,
  input  logic [REG_AW-1:0]                ex_rs1_addr,
  input  logic [REG_AW-1:0]                ex_rs2_addr,
  input  logic                             ex_mem_read,
  input  logic [REG_AW-1:0]                ex_rd_addr,
  input  logic [NUM_FWD_STAGES-1:0]        stg_reg_write,
  input  logic [NUM_FWD_STAGES*REG_AW-1:0] stg_rd_addr,
  input  logic                             mem_mem_write,
  input  logic [REG_AW-1:0]                mem_rs2_addr,
  input  logic                             dmem_busy,
  output logic [SEL_W-1:0]                 fwd_rs1_sel,
  output logic [SEL_W-1:0]                 fwd_rs2_sel,
  output logic [SEL_W-1:0]                 fwd_st_sel,
  output logic                             stall_pc,
  output logic                             stall_if_id,
  output logic                             bubble_id_ex,
  output logic                             freeze_all
`ifdef FWD_HAZARD_PERF_EN
  ,
  output logic [31:0]                      perf_lu_cycles,
  output logic [31:0]                      perf_wait_cycles
`endif
);

  localparam logic [3:0] LU_RELOAD =
    (LOAD_USE_CYCLES > 1) ? 4'(LOAD_USE_CYCLES - 2) : 4'd0;

  // ---------------------------------------------------------------- forwarding
  logic [SEL_W-1:0] rs1_sel_raw;
  logic [SEL_W-1:0] rs2_sel_raw;
  logic [SEL_W-1:0] st_sel_raw;

  fwd_match_sel #(.REG_AW(REG_AW), .NUM_STAGES(NUM_FWD_STAGES), .SEL_W(SEL_W)) u_rs1_sel (
    .addr      (ex_rs1_addr),
    .reg_write (stg_reg_write),
    .rd_addr   (stg_rd_addr),
    .sel       (rs1_sel_raw)
  );

  fwd_match_sel #(.REG_AW(REG_AW), .NUM_STAGES(NUM_FWD_STAGES), .SEL_W(SEL_W)) u_rs2_sel (
    .addr      (ex_rs2_addr),
    .reg_write (stg_reg_write),
    .rd_addr   (stg_rd_addr),
    .sel       (rs2_sel_raw)
  );

  // Store data already sits in MEM, so only stages older than MEM can supply
  // it. Feeding stages 1.. as a shifted vector makes the "+1" of the encoder
  // land exactly on the stage number.
  generate
    if (NUM_FWD_STAGES > 1) begin : g_st_fwd
      logic [SEL_W-1:0] st_match;
      fwd_match_sel #(.REG_AW(REG_AW), .NUM_STAGES(NUM_FWD_STAGES-1), .SEL_W(SEL_W)) u_st_sel (
        .addr      (mem_rs2_addr),
        .reg_write (stg_reg_write[NUM_FWD_STAGES-1:1]),
        .rd_addr   (stg_rd_addr[NUM_FWD_STAGES*REG_AW-1:REG_AW]),
        .sel       (st_match)
      );
      assign st_sel_raw = mem_mem_write ? st_match : SEL_W'(FWD_SEL_RF);
    end else begin : g_st_none
      assign st_sel_raw = SEL_W'(FWD_SEL_RF);
    end
  endgenerate

  // ---------------------------------------------------------------- hazard FSM
  hz_state_t  state;
  logic [3:0] cnt;
  logic       ret_lu;
  logic       load_use;
  logic       lu_active;

  assign load_use = ex_mem_read & (ex_rd_addr != '0)
                  & ((id_uses_rs1 & (id_rs1_addr == ex_rd_addr))
                   | (id_uses_rs2 & (id_rs2_addr == ex_rd_addr)));

  // A pending load-use stall, either running or parked behind a memory wait.
  // The cycle dmem_busy drops is already a working cycle, so a parked stall
  // resumes bubbling immediately rather than leaving an unprotected gap.
  assign lu_active = (state == LU_STALL) | ((state == MEM_WAIT) & ret_lu);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= RUN;
      cnt    <= 4'd0;
      ret_lu <= 1'b0;
    end else if (dmem_busy) begin
      // Memory wait dominates; remaining bubble count is held.
      state  <= MEM_WAIT;
      ret_lu <= lu_active;
    end else if (lu_active) begin
      ret_lu <= 1'b0;
      if (cnt == 4'd0) begin
        state <= RUN;
      end else begin
        state <= LU_STALL;
        cnt   <= cnt - 4'd1;
      end
    end else if (load_use && (LOAD_USE_CYCLES > 1)) begin
      state  <= LU_STALL;
      cnt    <= LU_RELOAD;
      ret_lu <= 1'b0;
    end else begin
      state  <= RUN;
      ret_lu <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- outputs
  logic lu_stall;
  assign lu_stall = rst_n & ~dmem_busy & (lu_active | load_use);

  assign stall_pc     = lu_stall;
  assign stall_if_id  = lu_stall;
  assign bubble_id_ex = lu_stall;
  assign freeze_all   = rst_n & dmem_busy;

  assign fwd_rs1_sel = rst_n ? rs1_sel_raw : '0;
  assign fwd_rs2_sel = rst_n ? rs2_sel_raw : '0;
  assign fwd_st_sel  = rst_n ? st_sel_raw  : '0;

`ifdef FWD_HAZARD_PERF_EN
  logic [31:0] lu_cycles_q;
  logic [31:0] wait_cycles_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lu_cycles_q   <= 32'd0;
      wait_cycles_q <= 32'd0;
    end else begin
      if (bubble_id_ex && (lu_cycles_q != '1))  lu_cycles_q   <= lu_cycles_q + 32'd1;
      if (freeze_all && (wait_cycles_q != '1))  wait_cycles_q <= wait_cycles_q + 32'd1;
    end
  end

  assign perf_lu_cycles   = rst_n ? lu_cycles_q   : 32'd0;
  assign perf_wait_cycles = rst_n ? wait_cycles_q : 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_hazard_unit
//  Description : Scoreboard bench for fwd_hazard_unit (3 stages, 3 bubbles
//                per load-use). A driver applies directed and random stimulus
//                and queues expected outputs from a reference model; a monitor
//                on the falling edge pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int L  = 3;
  localparam int SW = 2;

  typedef struct packed {
    logic          rst_n;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic          u1;
    logic          u2;
    logic [AW-1:0] ex_rs1;
    logic [AW-1:0] ex_rs2;
    logic          mr;
    logic [AW-1:0] ex_rd;
    logic [N-1:0]  we;
    logic [N*AW-1:0] rd;
    logic          mmw;
    logic [AW-1:0] mrs2;
    logic          busy;
  } stim_t;

  typedef struct packed {
    logic [SW-1:0] rs1;
    logic [SW-1:0] rs2;
    logic [SW-1:0] st;
    logic          bub;
    logic          frz;
    logic [31:0]   plu;
    logic [31:0]   pwt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [AW-1:0]   id_rs1_addr, id_rs2_addr, ex_rs1_addr, ex_rs2_addr, ex_rd_addr, mem_rs2_addr;
  logic            id_uses_rs1, id_uses_rs2, ex_mem_read, mem_mem_write, dmem_busy;
  logic [N-1:0]    stg_reg_write;
  logic [N*AW-1:0] stg_rd_addr;
  logic [SW-1:0]   fwd_rs1_sel, fwd_rs2_sel, fwd_st_sel;
  logic            stall_pc, stall_if_id, bubble_id_ex, freeze_all;
`ifdef FWD_HAZARD_PERF_EN
  logic [31:0]     perf_lu_cycles, perf_wait_cycles;
`endif

  fwd_hazard_unit #(
    .REG_AW(AW), .NUM_FWD_STAGES(N), .LOAD_USE_CYCLES(L)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .stg_reg_write(stg_reg_write), .stg_rd_addr(stg_rd_addr),
    .mem_mem_write(mem_mem_write), .mem_rs2_addr(mem_rs2_addr),
    .dmem_busy(dmem_busy),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel), .fwd_st_sel(fwd_st_sel),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id),
    .bubble_id_ex(bubble_id_ex), .freeze_all(freeze_all)
`ifdef FWD_HAZARD_PERF_EN
    , .perf_lu_cycles(perf_lu_cycles), .perf_wait_cycles(perf_wait_cycles)
`endif
  );

  int   total = 0;
  int   bad   = 0;
  exp_t exp_q[$];

  // Reference model: bubbles still owed for the current load-use, and
  // clock counts for the performance counters.
  int pending = 0;
  int lu_cnt  = 0;
  int wt_cnt  = 0;

  // Youngest writing stage (searching from 'first') whose nonzero rd equals a.
  function automatic logic [SW-1:0] m_fwd(logic [AW-1:0] a, logic [N-1:0] we,
                                          logic [N*AW-1:0] rd, int first);
    for (int i = first; i < N; i++) begin
      if (we[i] && rd[i*AW +: AW] != 0 && rd[i*AW +: AW] == a)
        return SW'(i + 1 - first);
    end
    return '0;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input stim_t s);
    exp_t e;
    bit   lu;
    @(posedge clk);
    #1;
    rst_n = s.rst_n;  id_rs1_addr = s.id_rs1; id_rs2_addr = s.id_rs2;
    id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; ex_rs1_addr = s.ex_rs1; ex_rs2_addr = s.ex_rs2;
    ex_mem_read = s.mr; ex_rd_addr = s.ex_rd; stg_reg_write = s.we; stg_rd_addr = s.rd;
    mem_mem_write = s.mmw; mem_rs2_addr = s.mrs2; dmem_busy = s.busy;
    e = '0;
    if (!s.rst_n) begin
      pending = 0; lu_cnt = 0; wt_cnt = 0;
    end else begin
      e.rs1 = m_fwd(s.ex_rs1, s.we, s.rd, 0);
      e.rs2 = m_fwd(s.ex_rs2, s.we, s.rd, 0);
      e.st  = s.mmw ? m_fwd(s.mrs2, s.we, s.rd, 1) : '0;
      e.plu = lu_cnt;
      e.pwt = wt_cnt;
      lu = s.mr && s.ex_rd != 0 &&
           ((s.u1 && s.id_rs1 == s.ex_rd) || (s.u2 && s.id_rs2 == s.ex_rd));
      if (s.busy) begin
        e.frz = 1'b1;
      end else if (pending > 0) begin
        e.bub = 1'b1; pending--;
      end else if (lu) begin
        e.bub = 1'b1; pending = L - 1;
      end
      lu_cnt += int'(e.bub);
      wt_cnt += int'(e.frz);
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(int n);
    stim_t s;
    s = '0; s.rst_n = 1'b1;
    for (int i = 0; i < n; i++) apply(s);
  endtask

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("fwd_rs1_sel",  32'(fwd_rs1_sel),  32'(e.rs1));
        check("fwd_rs2_sel",  32'(fwd_rs2_sel),  32'(e.rs2));
        check("fwd_st_sel",   32'(fwd_st_sel),   32'(e.st));
        check("stall_pc",     32'(stall_pc),     32'(e.bub));
        check("stall_if_id",  32'(stall_if_id),  32'(e.bub));
        check("bubble_id_ex", 32'(bubble_id_ex), 32'(e.bub));
        check("freeze_all",   32'(freeze_all),   32'(e.frz));
`ifdef FWD_HAZARD_PERF_EN
        check("perf_lu_cycles",   perf_lu_cycles,   e.plu);
        check("perf_wait_cycles", perf_wait_cycles, e.pwt);
`endif
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s, lu_s;
    rst_n = 1'b0; id_rs1_addr = '0; id_rs2_addr = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rs1_addr = '0; ex_rs2_addr = '0; ex_mem_read = 1'b0; ex_rd_addr = '0;
    stg_reg_write = '0; stg_rd_addr = '0; mem_mem_write = 1'b0; mem_rs2_addr = '0; dmem_busy = 1'b0;

    // Reset with live-looking inputs: every output must read 0.
    s = '0; s.ex_rs1 = 5; s.we = 3'b011; s.rd = {5'd0, 5'd5, 5'd5}; s.busy = 1'b1;
    apply(s); apply(s);

    // Operand forwarding: youngest wins, RegWrite gating, rd == 0 never forwards.
    s = '0; s.rst_n = 1'b1; s.ex_rs1 = 5; s.we = 3'b011; s.rd = {5'd0, 5'd5, 5'd5};
    apply(s);
    s.we = 3'b010; apply(s);
    s.we = 3'b111; s.rd = '0; apply(s);

    // Store-data forwarding from stage 1, only while a store is in MEM.
    s = '0; s.rst_n = 1'b1; s.mmw = 1'b1; s.mrs2 = 7; s.we = 3'b010; s.rd = {5'd0, 5'd7, 5'd0};
    apply(s);
    s.mmw = 1'b0; apply(s);

    // Load-use via rs2: three bubbles, then back to normal.
    lu_s = '0; lu_s.rst_n = 1'b1; lu_s.mr = 1'b1; lu_s.ex_rd = 4; lu_s.id_rs2 = 4; lu_s.u2 = 1'b1;
    apply(lu_s); idle(4);
    s = lu_s; s.u2 = 1'b0; apply(s); idle(2);

    // Memory wait from RUN for four cycles.
    s = '0; s.rst_n = 1'b1; s.busy = 1'b1;
    for (int i = 0; i < 4; i++) apply(s);
    idle(2);

    // Memory wait interrupting a load-use stall.
    apply(lu_s); idle(1); apply(s); apply(s); idle(4);

    // Reset in the middle of a load-use stall.
    apply(lu_s);
    s = '0; apply(s);
    idle(3);

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      s.rst_n  = ($urandom_range(0, 99) != 0);
      s.id_rs1 = AW'($urandom_range(0, 7));
      s.id_rs2 = AW'($urandom_range(0, 7));
      s.u1     = 1'($urandom);
      s.u2     = 1'($urandom);
      s.ex_rs1 = AW'($urandom_range(0, 7));
      s.ex_rs2 = AW'($urandom_range(0, 7));
      s.mr     = ($urandom_range(0, 9) < 3);
      s.ex_rd  = AW'($urandom_range(0, 7));
      s.we     = N'($urandom);
      for (int k = 0; k < N; k++) s.rd[k*AW +: AW] = AW'($urandom_range(0, 7));
      s.mmw    = 1'($urandom);
      s.mrs2   = AW'($urandom_range(0, 7));
      s.busy   = ($urandom_range(0, 9) < 2);
      apply(s);
    end
    idle(1);

    @(posedge clk);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
